axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving a 64-bit bus from a single-port 128-bit SRAM macro.
// One request at a time: reads take two cycles per beat, writes one cycle per beat.
//
//   state     | meaning
//   IDLE      | waiting for an AR or AW handshake
//   RD_REQ    | SRAM read enable for the current beat
//   RD_DATA   | beat presented on R until rready
//   WR_DATA   | accepting W beats, one SRAM write per beat
//   WR_RESP   | B response held until bready
module axi_sram_slave #(
  parameter int IDX_W   = 6,
  parameter bit RD_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arvalid,
  input  logic [3:0]         arid,
  input  logic [31:0]        araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  output logic               arready,
  output logic               rvalid,
  output logic [3:0]         rid,
  output logic [1:0]         rresp,
  output logic [63:0]        rdata,
  output logic               rlast,
  input  logic               rready,
  input  logic               awvalid,
  input  logic [3:0]         awid,
  input  logic [31:0]        awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  output logic               awready,
  input  logic               wvalid,
  input  logic [63:0]        wdata,
  input  logic [7:0]         wstrb,
  input  logic               wlast,
  output logic               wready,
  output logic               bvalid,
  output logic [3:0]         bid,
  output logic [1:0]         bresp,
  input  logic               bready,
  output logic [IDX_W-1:0]   sram_addr,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [127:0]       sram_wmask,
  output logic [127:0]       sram_wdata,
  input  logic [127:0]       sram_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        fresh_q, fresh_d;
  logic [63:0] rdata_q, rdata_d;

  logic        burst_ok;
  logic        beat_last;
  logic [31:0] addr_next;
  logic [63:0] rd_half;
  logic [63:0] strb_mask;

  assign burst_ok  = (burst_q == 2'b00) || (burst_q == 2'b01);
  assign beat_last = (cnt_q == len_q);
  assign addr_next = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;
  assign rd_half   = !burst_ok ? 64'd0 : (addr_q[3] ? sram_rdata[127:64] : sram_rdata[63:0]);

  assign arready = (state_q == S_IDLE) && (RD_PRIO || !awvalid);
  assign awready = (state_q == S_IDLE) && (!RD_PRIO || !arvalid);
  assign rvalid  = (state_q == S_RD_DATA);
  assign rlast   = rvalid && beat_last;
  assign rid     = id_q;
  assign rresp   = (rvalid && !burst_ok) ? 2'b10 : 2'b00;
  // Macro data lands during the first RD_DATA cycle; afterwards the captured copy is shown.
  assign rdata   = rvalid ? (fresh_q ? rd_half : rdata_q) : 64'd0;
  assign wready  = (state_q == S_WR_DATA);
  assign bvalid  = (state_q == S_WR_RESP);
  assign bid     = id_q;
  assign bresp   = (bvalid && (err_q || !burst_ok)) ? 2'b10 : 2'b00;

  always_comb begin
    strb_mask = '1;
    for (int i = 0; i < 8; i++) begin
      strb_mask[8*i +: 8] = wstrb[i] ? 8'h00 : 8'hFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    fresh_d    = 1'b0;
    rdata_d    = rdata_q;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_wmask = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          id_d = arid; addr_d = araddr; len_d = arlen; size_d = arsize; burst_d = arburst;
          cnt_d = 8'd0;
          state_d = S_RD_REQ;
        end else if (awvalid && awready) begin
          id_d = awid; addr_d = awaddr; len_d = awlen; size_d = awsize; burst_d = awburst;
          cnt_d = 8'd0;
          err_d = 1'b0;
          state_d = S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        sram_cen  = 1'b0;
        sram_addr = addr_q[IDX_W+3:4];
        fresh_d   = 1'b1;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (fresh_q) rdata_d = rd_half;
        if (rready) begin
          if (beat_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_next;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_DATA: begin
        if (wvalid) begin
          if (burst_ok) begin
            sram_cen   = 1'b0;
            sram_wen   = 1'b0;
            sram_addr  = addr_q[IDX_W+3:4];
            sram_wdata = {wdata, wdata};
            sram_wmask = addr_q[3] ? {strb_mask, 64'hFFFF_FFFF_FFFF_FFFF}
                                   : {64'hFFFF_FFFF_FFFF_FFFF, strb_mask};
          end
          if (wlast != beat_last) err_d = 1'b1;
          if (wlast || beat_last) begin
            state_d = S_WR_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      S_WR_RESP: begin
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      fresh_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      fresh_q <= fresh_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural 64x128 SRAM model.
module tb_axi_sram_slave;
  logic clk, rst_n;
  logic arvalid, arready, rvalid, rlast, rready;
  logic [3:0] arid, rid, awid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [63:0] rdata, wdata;
  logic awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [5:0] sram_addr;
  logic sram_cen, sram_wen;
  logic [127:0] sram_wmask, sram_wdata, sram_rdata;

  logic [127:0] mem [0:63];
  logic preload;
  int total, bad;

  localparam logic [63:0] M0_LO = 64'hB1B2B3B4B5B6B7B8;
  localparam logic [63:0] M0_HI = 64'hA1A2A3A4A5A6A7A8;
  localparam logic [63:0] M1_LO = 64'hD1D2D3D4D5D6D7D8;
  localparam logic [63:0] M1_HI = 64'hC1C2C3C4C5C6C7C8;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rvalid(rvalid), .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rready(rready),
    .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[0] <= {M0_HI, M0_LO};
      mem[1] <= {M1_HI, M1_LO};
      sram_rdata <= '0;
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= (mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({rvalid, bvalid, wready, rlast, sram_cen, sram_wen} !== 6'b000011) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000011", {rvalid, bvalid, wready, rlast, sram_cen, sram_wen});
    end
    total++;
    if ({rdata, rid, bid, rresp, bresp} !== 76'd0) begin
      bad++; $display("FAIL reset_resp got=%h exp=0", {rdata, rid, bid, rresp, bresp});
    end
    total++;
    if ({sram_wmask, sram_addr, sram_wdata} !== {{128{1'b1}}, 6'd0, 128'd0}) begin
      bad++; $display("FAIL reset_sram got=%h/%h/%h", sram_wmask, sram_addr, sram_wdata);
    end
    arvalid = 1'b1; araddr = 32'h0; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arid = 4'd0;
    @(posedge clk);
    #1 preload = 1'b0; rst_n = 1'b1;
    #2;
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL post_reset_arready got=%b exp=1", arready); end
    arvalid = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    awvalid = 1'b1; awid = 4'd5; awaddr = 32'h10; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01;
    #2;
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL sw_awready got=%b exp=1", awready); end
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 64'h1122334455667788; wstrb = 8'hFF; wlast = 1'b1;
    #2;
    total++;
    if ({wready, sram_cen, sram_wen, sram_addr} !== {3'b100, 6'd1}) begin
      bad++; $display("FAIL sw_strobe got=%b exp=100000001", {wready, sram_cen, sram_wen, sram_addr});
    end
    total++;
    if (sram_wmask !== {64'hFFFFFFFFFFFFFFFF, 64'h0}) begin
      bad++; $display("FAIL sw_wmask got=%h", sram_wmask);
    end
    total++;
    if (sram_wdata !== {2{64'h1122334455667788}}) begin
      bad++; $display("FAIL sw_wdata got=%h", sram_wdata);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    #2;
    total++;
    if ({bvalid, bid, bresp, wready} !== {1'b1, 4'd5, 2'b00, 1'b0}) begin
      bad++; $display("FAIL sw_b got=%b exp=1010100", {bvalid, bid, bresp, wready});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #2;
    total++;
    if ({bvalid, mem[1][63:0]} !== {1'b0, 64'h1122334455667788}) begin
      bad++; $display("FAIL sw_mem got=%b/%h exp=0/1122334455667788", bvalid, mem[1][63:0]);
    end
    tick();
  endtask

  task automatic test_burst_read();
    logic [63:0] exp_d [4];
    exp_d[0] = M0_LO; exp_d[1] = M0_HI; exp_d[2] = 64'h1122334455667788; exp_d[3] = M1_HI;
    arvalid = 1'b1; arid = 4'd3; araddr = 32'h0; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01;
    tick();
    arvalid = 1'b0;
    #2;
    total++;
    if ({rvalid, sram_cen, sram_addr} !== 8'b0_0_000000) begin
      bad++; $display("FAIL rd_req got=%b exp=00000000", {rvalid, sram_cen, sram_addr});
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      #2;
      total++;
      if ({rvalid, rlast, rid, rresp} !== {1'b1, 1'(b == 3), 4'd3, 2'b00} || rdata !== exp_d[b]) begin
        bad++; $display("FAIL rd_beat%0d got=%b/%h exp_last=%0d exp=%h", b, {rvalid, rlast, rid, rresp}, rdata, b == 3, exp_d[b]);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      if (b < 3) tick();
    end
    #2;
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL rd_end got=%b%b exp=01", rvalid, arready);
    end
    tick();
  endtask

  task automatic test_rready_stall();
    arvalid = 1'b1; arid = 4'd2; araddr = 32'h8; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
    tick();
    arvalid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #2;
      total++;
      if ({rvalid, rlast, sram_cen} !== 3'b111 || rdata !== M0_HI) begin
        bad++; $display("FAIL stall_c%0d got=%b/%h exp=111/%h", c, {rvalid, rlast, sram_cen}, rdata, M0_HI);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_priority();
    arvalid = 1'b1; arid = 4'd4; araddr = 32'h18; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
    awvalid = 1'b1; awid = 4'd6; awaddr = 32'h18; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01;
    #2;
    total++;
    if ({awready, arready} !== 2'b10) begin bad++; $display("FAIL prio_ready got=%b exp=10", {awready, arready}); end
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 64'hDEADBEEFCAFEF00D; wstrb = 8'h0F; wlast = 1'b1;
    #2;
    total++;
    if (sram_wmask !== {32'hFFFFFFFF, 32'h0, 64'hFFFFFFFFFFFFFFFF} || arready !== 1'b0) begin
      bad++; $display("FAIL prio_wmask got=%h ar=%b", sram_wmask, arready);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    #2;
    total++;
    if ({bvalid, bid, bresp, arready} !== {1'b1, 4'd6, 2'b00, 1'b0}) begin
      bad++; $display("FAIL prio_b got=%b exp=1011000", {bvalid, bid, bresp, arready});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #2;
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL prio_ar_after got=%b exp=1", arready); end
    tick();
    arvalid = 1'b0;
    tick();
    #2;
    total++;
    if ({rvalid, rid} !== {1'b1, 4'd4} || rdata !== 64'hC1C2C3C4CAFEF00D) begin
      bad++; $display("FAIL prio_rdata got=%b/%h exp=10100/c1c2c3c4cafef00d", {rvalid, rid}, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_early_wlast();
    awvalid = 1'b1; awid = 4'd1; awaddr = 32'h20; awlen = 8'd1; awsize = 3'd3; awburst = 2'b01;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF; wlast = 1'b1;
    #2;
    total++;
    if ({sram_cen, sram_wen, sram_addr} !== {2'b00, 6'd2}) begin
      bad++; $display("FAIL early_write got=%b exp=00000010", {sram_cen, sram_wen, sram_addr});
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    #2;
    total++;
    if ({bvalid, bresp, wready, sram_cen} !== 5'b1_10_0_1) begin
      bad++; $display("FAIL early_bresp got=%b exp=11001", {bvalid, bresp, wready, sram_cen});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #2;
    total++;
    if ({bvalid, awready} !== 2'b01 || mem[2] !== {64'd0, 64'h0123456789ABCDEF}) begin
      bad++; $display("FAIL early_idle got=%b/%h", {bvalid, awready}, mem[2]);
    end
    tick();
  endtask

  task automatic test_wrap_bursts();
    awvalid = 1'b1; awid = 4'd8; awaddr = 32'h30; awlen = 8'd1; awsize = 3'd3; awburst = 2'b10;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 64'hFFFF0000FFFF0000; wstrb = 8'hFF;
    for (int b = 0; b < 2; b++) begin
      wlast = 1'(b == 1);
      #2;
      total++;
      if ({wready, sram_cen} !== 2'b11) begin
        bad++; $display("FAIL wrap_w%0d got=%b exp=11", b, {wready, sram_cen});
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    #2;
    total++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd8, 2'b10} || mem[3] !== 128'd0) begin
      bad++; $display("FAIL wrap_b got=%b/%h exp=1100010", {bvalid, bid, bresp}, mem[3]);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    arvalid = 1'b1; arid = 4'd7; araddr = 32'h0; arlen = 8'd0; arsize = 3'd3; arburst = 2'b11;
    tick();
    arvalid = 1'b0;
    tick();
    #2;
    total++;
    if ({rvalid, rlast, rresp} !== 4'b1110 || rdata !== 64'd0) begin
      bad++; $display("FAIL wrap_r got=%b/%h exp=1110/0", {rvalid, rlast, rresp}, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_narrow_and_fixed();
    for (int p = 0; p < 2; p++) begin
      arvalid = 1'b1; arid = 4'd1; arlen = 8'd1;
      araddr  = (p == 0) ? 32'h4 : 32'h8;
      arsize  = (p == 0) ? 3'd2 : 3'd3;
      arburst = (p == 0) ? 2'b01 : 2'b00;
      tick();
      arvalid = 1'b0;
      tick();
      for (int b = 0; b < 2; b++) begin
        #2;
        total++;
        if (rdata !== ((p == 0 && b == 0) ? M0_LO : M0_HI) || rlast !== 1'(b == 1)) begin
          bad++; $display("FAIL nf_p%0d_b%0d got=%h last=%b", p, b, rdata, rlast);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        if (b == 0) tick();
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    arvalid = 1'b1; arid = 4'd2; araddr = 32'h0; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01;
    tick();
    arvalid = 1'b0;
    tick();
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rvalid, rlast, sram_cen} !== 3'b001 || rdata !== 64'd0) begin
      bad++; $display("FAIL midrst got=%b/%h exp=001/0", {rvalid, rlast, sram_cen}, rdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    arvalid = 1'b1; arid = 4'd9; araddr = 32'h10; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
    #2;
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL midrst_ar got=%b exp=1", arready); end
    tick();
    arvalid = 1'b0;
    tick();
    #2;
    total++;
    if ({rvalid, rlast, rid} !== {2'b11, 4'd9} || rdata !== 64'h1122334455667788) begin
      bad++; $display("FAIL midrst_read got=%b/%h exp=111001/1122334455667788", {rvalid, rlast, rid}, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; preload = 1'b1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    test_reset();
    test_single_write();
    test_burst_read();
    test_rready_stall();
    test_priority();
    test_early_wlast();
    test_wrap_bursts();
    test_narrow_and_fixed();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
